// File: rtl/rx_frame_ctrl.sv
// Receive-path sequencer: hunts preamble + SFD on the CDR bit stream, captures the
// PHR length, and pushes exactly that many PSDU bytes (LSB-first) into the RX FIFO.
module rx_frame_ctrl #(
  parameter int          WIDTH    = 8,
  parameter logic [7:0]  SFD      = 8'hA7,
  parameter int          PRE_BITS = 32,
  parameter int          TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cdr_en,
  input  logic             bit_valid,
  input  logic             bit_data,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_wr_data,
  output logic [6:0]       frame_len,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, HUNT = 2'd1, LEN = 2'd2, DATA = 2'd3} state_t;

  localparam int ZW = $clog2(PRE_BITS + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int BW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] next_byte;
  logic [WIDTH-1:0] byte_q;
  logic [ZW-1:0]    zero_cnt;
  logic             pre_ok;
  logic [2:0]       sfd_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [6:0]       byte_cnt;
  logic [TW-1:0]    idle_cnt;
  logic             byte_pend;
  logic             full_q;

  // New bits enter at the MSB so a completed byte reads LSB-first.
  always_comb begin
    next_byte = {bit_data, shreg[WIDTH-1:1]};
  end

  assign busy      = (state == LEN) || (state == DATA);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shreg        <= '0;
      byte_q       <= '0;
      zero_cnt     <= '0;
      pre_ok       <= 1'b0;
      sfd_cnt      <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      idle_cnt     <= '0;
      byte_pend    <= 1'b0;
      full_q       <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      frame_len    <= '0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (!cdr_en) begin
        state     <= IDLE;
        shreg     <= '0;
        zero_cnt  <= '0;
        pre_ok    <= 1'b0;
        sfd_cnt   <= '0;
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        idle_cnt  <= '0;
        byte_pend <= 1'b0;
        full_q    <= 1'b0;
      end else begin
        if (bit_valid && state != IDLE) shreg <= next_byte;
        case (state)
          IDLE: state <= HUNT;
          HUNT: begin
            if (bit_valid) begin
              if (sfd_cnt != 3'd0) begin
                if (sfd_cnt == 3'd7) begin
                  // Window complete; hunt counters restart whether or not it matched.
                  if (next_byte[7:0] == SFD) begin
                    state    <= LEN;
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                    err_code <= 2'd0;
                  end
                  pre_ok   <= 1'b0;
                  zero_cnt <= '0;
                  sfd_cnt  <= '0;
                end else begin
                  sfd_cnt <= sfd_cnt + 3'd1;
                end
              end else if (bit_data) begin
                zero_cnt <= '0;
                if (pre_ok) sfd_cnt <= 3'd1;
              end else if (zero_cnt != ZW'(PRE_BITS)) begin
                zero_cnt <= zero_cnt + 1'b1;
                if (zero_cnt == ZW'(PRE_BITS - 1)) pre_ok <= 1'b1;
              end
            end
          end
          LEN: begin
            if (bit_valid) begin
              idle_cnt <= '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == BW'(WIDTH - 1)) begin
                bit_cnt   <= '0;
                frame_len <= next_byte[6:0];
                if (next_byte[6:0] == 7'd0) begin
                  frame_err <= 1'b1;
                  err_code  <= 2'd1;
                  state     <= HUNT;
                end else begin
                  byte_cnt <= '0;
                  state    <= DATA;
                end
              end
            end else if (idle_cnt + 1'b1 == TW'(TIMEOUT)) begin
              frame_err <= 1'b1;
              err_code  <= 2'd3;
              idle_cnt  <= '0;
              state     <= HUNT;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          DATA: begin
            // A byte completed on the previous edge is written (or rejected) here.
            if (byte_pend) begin
              byte_pend <= 1'b0;
              if (full_q) begin
                frame_err <= 1'b1;
                err_code  <= 2'd2;
                state     <= HUNT;
              end else begin
                fifo_wr_en   <= 1'b1;
                fifo_wr_data <= byte_q;
                byte_cnt     <= byte_cnt + 7'd1;
                if (byte_cnt + 7'd1 == frame_len) begin
                  frame_done <= 1'b1;
                  state      <= HUNT;
                end
              end
            end
            if (bit_valid) begin
              idle_cnt <= '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == BW'(WIDTH - 1)) begin
                bit_cnt   <= '0;
                byte_pend <= 1'b1;
                full_q    <= fifo_full;
                byte_q    <= next_byte;
              end
            end else if (idle_cnt + 1'b1 == TW'(TIMEOUT)) begin
              frame_err <= 1'b1;
              err_code  <= 2'd3;
              idle_cnt  <= '0;
              byte_pend <= 1'b0;
              state     <= HUNT;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: a table of whole frames plus hand-written
// sequences for preamble/SFD rejection, timeout, enable drop and mid-byte reset.
module tb_rx_frame_ctrl;

  localparam int GAP = 25;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cdr_en;
  logic       bit_valid;
  logic       bit_data;
  logic       fifo_full;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic [6:0] frame_len;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic [1:0] dbg_state;

  rx_frame_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cdr_en(cdr_en), .bit_valid(bit_valid),
    .bit_data(bit_data), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .frame_len(frame_len), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #10 clk = ~clk;

  // Monitor: owns all event counters; the test reads deltas against snapshots.
  int         wr_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_cnt = 0;
  logic [7:0] got_mem[256];

  always @(negedge clk) begin
    if (reset_n) begin
      if (fifo_wr_en) begin
        if (wr_cnt < 256) got_mem[wr_cnt] = fifo_wr_data;
        wr_cnt = wr_cnt + 1;
      end
      if (frame_done) done_cnt = done_cnt + 1;
      if (frame_err) err_cnt = err_cnt + 1;
      if (frame_done && frame_err) both_cnt = both_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  // Scoreboard
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         b_wr, b_done, b_err, b_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    b_wr   = wr_cnt;
    b_done = done_cnt;
    b_err  = err_cnt;
    b_busy = busy_cnt;
  endtask

  task automatic check_writes(input string name);
    check({name, "_wr_count"}, 64'(wr_cnt - b_wr), 64'(exp_q.size()));
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check({name, "_wr_data"}, 64'(got_mem[b_wr + k]), 64'(e));
    end
    exp_q.delete();
  endtask

  // Driver tasks (called just after a rising edge)
  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_data  = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    repeat (GAP - 1) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic restart();
    cdr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cdr_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [7:0]  phr;
    int          n_send;
    logic [39:0] payload;
    int          full_at;
    int          exp_wr;
    int          exp_done;
    int          exp_err;
    logic [1:0]  exp_code;
    logic [6:0]  exp_len;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"nominal",  8'h03, 3, 40'h0000332211, -1, 3, 1, 0, 2'd0, 7'd3};
    vecs[1] = '{"zero_len", 8'h80, 0, 40'h0,          -1, 0, 0, 1, 2'd1, 7'd0};
    vecs[2] = '{"len1",     8'h01, 1, 40'h00000000FF, -1, 1, 1, 0, 2'd0, 7'd1};
    vecs[3] = '{"overflow", 8'h05, 3, 40'h0000030201,  2, 2, 0, 1, 2'd2, 7'd5};
    vecs[4] = '{"bit7_ign", 8'h82, 2, 40'h0000005AA5, -1, 2, 1, 0, 2'd0, 7'd2};

    reset_n   = 1'b0;
    cdr_en    = 1'b0;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {fifo_wr_en, fifo_wr_data, frame_len, busy, frame_done,
                            frame_err, err_code, dbg_state}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven complete frames
    for (int v = 0; v < 5; v++) begin
      restart();
      snap();
      send_zeros(32);
      send_byte(8'hA7);
      send_byte(vecs[v].phr);
      for (int k = 0; k < vecs[v].n_send; k++) begin
        if (k == vecs[v].full_at) fifo_full = 1'b1;
        send_byte(vecs[v].payload[k*8 +: 8]);
      end
      repeat (20) @(posedge clk);
      #1;
      fifo_full = 1'b0;
      for (int k = 0; k < vecs[v].exp_wr; k++) exp_q.push_back(vecs[v].payload[k*8 +: 8]);
      check_writes(vecs[v].name);
      check({vecs[v].name, "_done"}, 64'(done_cnt - b_done), 64'(vecs[v].exp_done));
      check({vecs[v].name, "_err"}, 64'(err_cnt - b_err), 64'(vecs[v].exp_err));
      check({vecs[v].name, "_code"}, 64'(err_code), 64'(vecs[v].exp_code));
      check({vecs[v].name, "_len"}, 64'(frame_len), 64'(vecs[v].exp_len));
      check({vecs[v].name, "_hunt"}, {busy, dbg_state}, {1'b0, 2'd1});
    end

    // Short preamble: the whole frame must be ignored, then a proper one accepted
    restart();
    snap();
    send_zeros(20);
    send_byte(8'hA7);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("short_pre_no_busy", 64'(busy_cnt - b_busy), 64'd0);
    check("short_pre_no_wr", 64'(wr_cnt - b_wr), 64'd0);
    snap();
    send_zeros(32);
    send_byte(8'hA7);
    send_byte(8'h01);
    send_byte(8'h44);
    repeat (5) @(posedge clk);
    #1;
    exp_q.push_back(8'h44);
    check_writes("short_pre_retry");
    check("short_pre_retry_done", 64'(done_cnt - b_done), 64'd1);

    // Bad SFD: the 8th window bit is the first zero of the next preamble, so it
    // is consumed by the mismatch; 33 zeros leave a full 32-bit run afterwards.
    restart();
    snap();
    send_zeros(40);
    send_byte(8'hA6);
    send_zeros(1);
    check("bad_sfd_rejected", 64'(busy_cnt - b_busy), 64'd0);
    send_zeros(32);
    send_byte(8'hA7);
    check("good_sfd_len", {busy, dbg_state}, {1'b1, 2'd2});

    // Timeout mid-payload
    restart();
    snap();
    send_zeros(32);
    send_byte(8'hA7);
    send_byte(8'h03);
    send_byte(8'h11);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    repeat (970) @(posedge clk);
    #1;
    check("timeout_not_early", 64'(err_cnt - b_err), 64'd0);
    repeat (60) @(posedge clk);
    #1;
    check("timeout_err", 64'(err_cnt - b_err), 64'd1);
    check("timeout_code", 64'(err_code), 64'd3);
    check("timeout_busy", 64'(busy), 64'd0);
    exp_q.push_back(8'h11);
    check_writes("timeout");

    // cdr_en drop mid-DATA
    restart();
    snap();
    send_zeros(32);
    send_byte(8'hA7);
    send_byte(8'h03);
    send_byte(8'h11);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    cdr_en = 1'b0;
    @(posedge clk); #1;
    check("drop_idle", {busy, dbg_state}, {1'b0, 2'd0});
    repeat (30) @(posedge clk);
    #1;
    check("drop_no_done", 64'(done_cnt - b_done), 64'd0);
    check("drop_no_err", 64'(err_cnt - b_err), 64'd0);
    check("drop_keeps_len", 64'(frame_len), 64'd3);
    check("drop_keeps_code", 64'(err_code), 64'd0);
    exp_q.push_back(8'h11);
    check_writes("drop");

    // Reset mid-byte
    restart();
    snap();
    send_zeros(32);
    send_byte(8'hA7);
    send_byte(8'h02);
    send_byte(8'h77);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", {fifo_wr_en, fifo_wr_data, frame_len, busy, frame_done,
                               frame_err, err_code, dbg_state}, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    exp_q.push_back(8'h77);
    check_writes("midreset");

    check("done_err_exclusive", 64'(both_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Receive-path sequencer between the CDR bit output and the RX byte FIFO of the Zigbee (802.15.4 O-QPSK) receiver.
- Hunts for preamble + SFD, deserialises bits LSB-first, captures the PHR frame length, and pushes exactly that many PSDU bytes into the FIFO.
- Reports frame completion and errors (bad length, FIFO overflow, bit timeout) to the APB status logic.

Parameters:
- WIDTH, 8, FIFO data width; byte assembly width.
- SFD, 8'hA7, start-of-frame delimiter value, received LSB first.
- PRE_BITS, 32, minimum run of consecutive 0 bits that qualifies a preamble.
- TIMEOUT, 1024, clk cycles without bit_valid that abort a frame in LEN/DATA.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- cdr_en  in  1  receiver enable; low forces IDLE
- bit_valid  in  1  one-cycle strobe, bit_data valid
- bit_data  in  1  received bit
- fifo_full  in  1  RX FIFO full flag
- fifo_wr_en  out  1  one-cycle write strobe to FIFO
- fifo_wr_data  out  WIDTH  byte to FIFO
- frame_len  out  7  PHR length of current/last frame
- busy  out  1  high in LEN or DATA
- frame_done  out  1  one-cycle pulse, frame fully written
- frame_err  out  1  one-cycle pulse, frame aborted with error
- err_code  out  2  0 none, 1 bad length, 2 overflow, 3 timeout; held until next frame_err or SFD match

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low. All outputs reset to 0; state is IDLE; all counters and the shift register are cleared.
- States: IDLE, HUNT, LEN, DATA.
- IDLE: go to HUNT on the cycle after cdr_en=1.
- cdr_en=0 in any state forces IDLE on the next edge and clears counters. No frame_done/frame_err pulse. frame_len and err_code are kept.
- Bits are consumed only on cycles with bit_valid=1. bit_valid may be high every cycle.
- Deserialiser: 8-bit shift register, new bit enters at the MSB and shifts right. After 8 bits the register holds the byte LSB-first.
- HUNT, zero counter:
  - zero_cnt counts consecutive 0 bits and saturates at PRE_BITS. Any 1 bit resets it.
  - pre_ok is set when zero_cnt reaches PRE_BITS.
- HUNT, SFD check:
  - With pre_ok=1, the first 1 bit starts sfd_cnt at 1. Each following bit increments sfd_cnt.
  - At sfd_cnt=8, compare the window to SFD.
  - Match: go to LEN, clear the bit counter, set err_code=0.
  - Mismatch: clear pre_ok, zero_cnt and sfd_cnt; stay in HUNT.
- LEN:
  - Collect 8 bits; frame_len <= byte[6:0]; byte[7] is ignored.
  - frame_len=0: frame_err pulse, err_code=1, return to HUNT.
  - Otherwise go to DATA with byte_cnt=0.
- DATA, byte write:
  - On each completed byte (bit_valid carrying the 8th bit at edge N), at edge N+1: fifo_wr_en=1 for exactly one cycle, fifo_wr_data=byte, byte_cnt+1.
  - fifo_full is sampled in the same cycle as the completing bit_valid. If it is 1: no write; frame_err pulse and err_code=2 at N+1; return to HUNT; remaining bits are discarded.
- DATA, completion: when the written byte is number frame_len, frame_done pulses in the same cycle as that last fifo_wr_en, then return to HUNT. frame_done and frame_err are never high together.
- Timeout: an idle counter runs in LEN and DATA and is cleared on every bit_valid. At TIMEOUT cycles: frame_err pulse, err_code=3, return to HUNT.
- busy=1 exactly in LEN and DATA.
- Reset mid-frame: immediate IDLE; a partial byte is never written.
- Width rules: byte_cnt is 7 bits, compared against frame_len. The idle counter is $clog2(TIMEOUT)+1 bits and does not wrap.

Test Plan:
- Nominal frame: cdr_en=1; 32 zeros, SFD A7 (bits 1,1,1,0,0,1,0,1), PHR 0x03, payload 0x11 0x22 0x33, one bit every 25 clk -> three fifo_wr_en pulses with 0x11, 0x22, 0x33; frame_done on the third; frame_len=3; err_code=0.
- Short preamble: 20 zeros then SFD and a valid frame -> no LEN entry; no fifo_wr_en. Then 32 zeros + SFD -> frame accepted.
- Bad SFD: 40 zeros, then 0xA6 LSB-first, then 32 zeros + A7 -> first attempt rejected; second reaches LEN.
- Zero length: PHR 0x80 (len 0) -> frame_err with err_code=1; no writes; busy falls; back to HUNT.
- Overflow: PHR 0x05, fifo_full forced to 1 before the 3rd byte -> 2 writes, frame_err with err_code=2, no frame_done.
- Timeout and abort: stop bit_valid mid-payload for 1024 clk -> frame_err with err_code=3. Separate run: drop cdr_en mid-DATA -> IDLE next cycle, no pulses. Separate run: reset_n low mid-byte -> all outputs 0.
